// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address and fills the IF/ID pipeline register. Handles hazard freeze,
// branch redirect with flush, and a memory-ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_inst,
    output logic [31:0] imem_addr,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        align_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_reg,       state_next;
    logic [31:0] pc_reg,          pc_next_val;
    logic [31:0] id_pc_reg,       id_pc_next;
    logic [31:0] id_inst_reg,     id_inst_next;
    logic        id_valid_reg,    id_valid_next;
    logic        align_err_reg,   align_err_next;
    logic [31:0] fetch_count_reg, fetch_count_next;
    logic [31:0] pc_plus4;

    // Sequential PC successor; wraps naturally at 2^32.
    assign pc_plus4 = pc_reg + 32'd4;

    // Register all pipeline state; reset overrides every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            id_pc_reg       <= 32'h0000_0000;
            id_inst_reg     <= BUBBLE_INST;
            id_valid_reg    <= 1'b0;
            align_err_reg   <= 1'b0;
            fetch_count_reg <= 32'h0000_0000;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next_val;
            id_pc_reg       <= id_pc_next;
            id_inst_reg     <= id_inst_next;
            id_valid_reg    <= id_valid_next;
            align_err_reg   <= align_err_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    // Next-state logic: branch beats freeze, freeze beats a stalled memory,
    // otherwise the returned word is captured and the PC advances.
    always_comb begin
        state_next       = state_reg;
        pc_next_val      = pc_reg;
        id_pc_next       = id_pc_reg;
        id_inst_next     = id_inst_reg;
        id_valid_next    = id_valid_reg;
        align_err_next   = align_err_reg;
        fetch_count_next = fetch_count_reg;

        if (branch_taken) begin
            // Redirect to the word-aligned target and flush the slot; a
            // misaligned target is remembered until reset.
            pc_next_val    = {branch_addr[31:2], 2'b00};
            id_pc_next     = 32'h0000_0000;
            id_inst_next   = BUBBLE_INST;
            id_valid_next  = 1'b0;
            state_next     = RUN;
            if (branch_addr[1:0] != 2'b00) begin
                align_err_next = 1'b1;
            end
        end else if (freeze) begin
            // Hold everything: defaults already keep current values.
        end else if (!imem_ready) begin
            // Memory is slow: keep the address on the bus, push a bubble.
            id_pc_next    = 32'h0000_0000;
            id_inst_next  = BUBBLE_INST;
            id_valid_next = 1'b0;
            state_next    = WAIT;
        end else begin
            pc_next_val      = pc_plus4;
            id_pc_next       = pc_plus4;
            id_inst_next     = imem_inst;
            id_valid_next    = 1'b1;
            fetch_count_next = fetch_count_reg + 32'd1;
            state_next       = RUN;
        end
    end

    assign imem_addr   = pc_reg;
    assign id_pc       = id_pc_reg;
    assign id_inst     = id_inst_reg;
    assign id_valid    = id_valid_reg;
    assign align_err   = align_err_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic,
// every edge compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_ready;
    logic [31:0] imem_inst;
    logic [31:0] imem_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        align_err;
    logic [31:0] fetch_count;

    int n_assert;
    int n_fail;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    logic        m_align_err;
    logic [31:0] m_count;

    fetch_stage #(
        .RESET_PC    (RESET_PC),
        .BUBBLE_INST (BUBBLE_INST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_ready   (imem_ready),
        .imem_inst    (imem_inst),
        .imem_addr    (imem_addr),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .align_err    (align_err),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a fixed word at address 0, a scrambled pattern elsewhere.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0014;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_inst = rom(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr",   imem_addr,         m_pc);
        chk("id_pc",       id_pc,             m_id_pc);
        chk("id_inst",     id_inst,           m_id_inst);
        chk("id_valid",    {31'b0, id_valid}, {31'b0, m_id_valid});
        chk("align_err",   {31'b0, align_err},{31'b0, m_align_err});
        chk("fetch_count", fetch_count,       m_count);
    endtask

    // Apply one cycle of inputs, advance the model, then compare.
    task automatic step(input logic r, input logic f, input logic b,
                        input logic [31:0] ba, input logic rdy);
        @(negedge clk);
        rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_id_pc = 0; m_id_inst = BUBBLE_INST;
            m_id_valid = 0; m_align_err = 0; m_count = 0;
        end else if (b) begin
            m_pc = ba & ~32'h3;
            m_id_pc = 0; m_id_inst = BUBBLE_INST; m_id_valid = 0;
            if (ba % 4 != 0) m_align_err = 1;
        end else if (f) begin
            // nothing changes
        end else if (!rdy) begin
            m_id_pc = 0; m_id_inst = BUBBLE_INST; m_id_valid = 0;
        end else begin
            m_id_inst  = rom(m_pc);
            m_pc       = m_pc + 4;
            m_id_pc    = m_pc;
            m_id_valid = 1;
            m_count    = m_count + 1;
        end
        #1;
        $display("step rst=%0b frz=%0b br=%0b ba=%h rdy=%0b -> addr=%h id_pc=%h inst=%h v=%0b ae=%0b cnt=%0d",
                 r, f, b, ba, rdy, imem_addr, id_pc, id_inst, id_valid, align_err, fetch_count);
        check_all();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 1);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0; imem_ready = 1;
        m_pc = 0; m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_align_err = 0; m_count = 0;

        // Reset then free run
        step(1, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        chk("first_id_pc",   id_pc,   32'h4);
        chk("first_id_inst", id_inst, 32'hE3A0_0014);
        run(3);
        chk("run4_count", fetch_count, 32'd4);
        chk("run4_addr",  imem_addr,   32'd16);

        // Memory stall at pc=16
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("wait_addr", imem_addr, 32'd16);
        step(0, 0, 0, 32'h0, 1);
        chk("wait_resume_pc", id_pc,       32'd20);
        chk("wait_count",     fetch_count, 32'd5);

        // Freeze at pc=8
        step(0, 0, 1, 32'h8, 1);
        run(0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 1);
        chk("freeze_addr", imem_addr, 32'd8);
        step(0, 0, 0, 32'h0, 1);
        chk("freeze_release", imem_addr, 32'd12);

        // Branch while frozen
        step(0, 1, 1, 32'h90, 1);
        chk("br_frz_addr", imem_addr, 32'h90);
        step(0, 0, 0, 32'h0, 1);
        chk("br_frz_id_pc", id_pc, 32'h94);

        // Misaligned target and sticky error
        step(0, 0, 1, 32'h46, 1);
        chk("mis_addr", imem_addr, 32'h44);
        run(3);
        chk("mis_sticky", {31'b0, align_err}, 32'd1);

        // Back-to-back branches
        step(0, 0, 1, 32'h200, 1);
        step(0, 0, 1, 32'h300, 0);
        run(1);

        // Reset during WAIT and during freeze
        step(0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        chk("rst_wait_ae", {31'b0, align_err}, 32'd0);
        run(2);
        step(0, 1, 0, 32'h0, 1);
        step(1, 1, 0, 32'h0, 1);
        chk("rst_frz_cnt", fetch_count, 32'd0);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 32'h0, 1);
        chk("wrap_id_pc", id_pc,     32'h0);
        chk("wrap_addr",  imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r, f, b, rdy;
            logic [31:0] ba;
            r   = ($urandom_range(0, 99) < 3);
            f   = ($urandom_range(0, 99) < 25);
            b   = ($urandom_range(0, 99) < 15);
            rdy = ($urandom_range(0, 99) < 70);
            ba  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(r, f, b, ba, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
